// File: rtl/scr_base_l3_bank_req_sched.sv
// L3 bank ingress scheduler: round-robin core arbitration, ROB entry allocation, registered alloc stage.
// Optional same-line hazard blocking is compiled in with SCR_BASE_L3_BANK_SCHED_HAZARD_EN.
module scr_base_l3_bank_req_sched #(
    parameter int CORE_NUM  = 4,
    parameter int ROB_DEPTH = 32,
    parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
    parameter int ADDR_W    = 27,
    parameter int CORE_W    = $clog2(CORE_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CORE_NUM-1:0]        req_vd,
    input  logic [CORE_NUM*ADDR_W-1:0] req_addr,
    output logic [CORE_NUM-1:0]        req_rdy,
    output logic                       alloc_vd,
    input  logic                       alloc_rdy,
    output logic [CORE_W-1:0]          alloc_core,
    output logic [ADDR_W-1:0]          alloc_addr,
    output logic [ROB_PTR_W-1:0]       alloc_idx,
    input  logic                       rel_vd,
    input  logic [ROB_PTR_W-1:0]       rel_idx,
    output logic [ROB_PTR_W:0]         rob_cnt,
    output logic                       rob_full,
    output logic                       err
);
    localparam logic [ROB_PTR_W:0] FULL_CNT = (ROB_PTR_W+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [CORE_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                 alloc_vd_q, alloc_vd_d;
    logic [CORE_W-1:0]    alloc_core_q, alloc_core_d;
    logic [ADDR_W-1:0]    alloc_addr_q, alloc_addr_d;
    logic [ROB_PTR_W-1:0] alloc_idx_q, alloc_idx_d;
    logic [ROB_PTR_W:0]   cnt_q, cnt_d;
    logic                 full_q, full_d;
    logic                 err_q, err_d;

    logic [CORE_NUM-1:0]  hazard, eligible;
    logic                 gnt_found;
    logic [CORE_W-1:0]    gnt_core;
    logic [ADDR_W-1:0]    gnt_addr;
    logic [ROB_PTR_W-1:0] free_idx;
    logic                 slot_free, xfer, rel_ok;

`ifdef SCR_BASE_L3_BANK_SCHED_HAZARD_EN
    logic [ADDR_W-1:0] line_q [ROB_DEPTH];

    // An entry being released this cycle is still busy here, so its line stays blocked one more cycle.
    always_comb begin
        hazard = '0;
        for (int c = 0; c < CORE_NUM; c++) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                if (busy_q[e] && (line_q[e] == req_addr[c*ADDR_W +: ADDR_W])) begin
                    hazard[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            line_q[free_idx] <= gnt_addr;
        end
    end
`else
    assign hazard = '0;
`endif

    assign eligible  = req_vd & ~hazard;
    assign slot_free = !alloc_vd_q || alloc_rdy;
    assign rel_ok    = rel_vd && busy_q[rel_idx];

    always_comb begin
        int c;
        gnt_found = 1'b0;
        gnt_core  = '0;
        for (int i = 0; i < CORE_NUM; i++) begin
            c = int'(rr_ptr_q) + i;
            if (c >= CORE_NUM) begin
                c = c - CORE_NUM;
            end
            if (!gnt_found && eligible[CORE_W'(c)]) begin
                gnt_found = 1'b1;
                gnt_core  = CORE_W'(c);
            end
        end
    end

    always_comb begin
        gnt_addr = '0;
        for (int c = 0; c < CORE_NUM; c++) begin
            if (CORE_W'(c) == gnt_core) begin
                gnt_addr = req_addr[c*ADDR_W +: ADDR_W];
            end
        end
    end

    // Lowest-index free entry: scan downward so the smallest index is assigned last.
    always_comb begin
        free_idx = '0;
        for (int e = ROB_DEPTH-1; e >= 0; e--) begin
            if (!busy_q[e]) begin
                free_idx = ROB_PTR_W'(e);
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (gnt_found && slot_free && !full_q) begin
            req_rdy[gnt_core] = 1'b1;
        end
    end

    assign xfer = |(req_rdy & req_vd);

    always_comb begin
        busy_d       = busy_q;
        rr_ptr_d     = rr_ptr_q;
        alloc_vd_d   = alloc_vd_q;
        alloc_core_d = alloc_core_q;
        alloc_addr_d = alloc_addr_q;
        alloc_idx_d  = alloc_idx_q;
        err_d        = err_q;
        if (rel_vd) begin
            if (busy_q[rel_idx]) begin
                busy_d[rel_idx] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (xfer) begin
            busy_d[free_idx] = 1'b1;
            alloc_vd_d       = 1'b1;
            alloc_core_d     = gnt_core;
            alloc_addr_d     = gnt_addr;
            alloc_idx_d      = free_idx;
            rr_ptr_d         = (int'(gnt_core) == CORE_NUM-1) ? '0 : gnt_core + 1'b1;
        end else if (alloc_rdy) begin
            alloc_vd_d = 1'b0;
        end
        cnt_d  = cnt_q + (ROB_PTR_W+1)'(xfer) - (ROB_PTR_W+1)'(rel_ok);
        full_d = (cnt_d == FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            rr_ptr_q     <= '0;
            alloc_vd_q   <= 1'b0;
            alloc_core_q <= '0;
            alloc_addr_q <= '0;
            alloc_idx_q  <= '0;
            cnt_q        <= '0;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            rr_ptr_q     <= rr_ptr_d;
            alloc_vd_q   <= alloc_vd_d;
            alloc_core_q <= alloc_core_d;
            alloc_addr_q <= alloc_addr_d;
            alloc_idx_q  <= alloc_idx_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            err_q        <= err_d;
        end
    end

    assign alloc_vd   = alloc_vd_q;
    assign alloc_core = alloc_core_q;
    assign alloc_addr = alloc_addr_q;
    assign alloc_idx  = alloc_idx_q;
    assign rob_cnt    = cnt_q;
    assign rob_full   = full_q;
    assign err        = err_q;

endmodule
